// File: rtl/reservation_station_array.sv
// Multi-entry, age-ordered reservation station. Snoops NUM_CDB result buses
// and issues the oldest fully-ready entry to its functional unit.
module reservation_station_array #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OP_W      = 4,
  parameter int unsigned ROB_IDX_W = 3,
  parameter int unsigned NUM_CDB   = 2
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           valid_input_in,
  input  logic [OP_W-1:0]                opcode_in,
  input  logic [ROB_IDX_W-1:0]           rob_idx_in,
  input  logic [DATA_W-1:0]              V_i_in,
  input  logic [DATA_W-1:0]              V_j_in,
  input  logic [ROB_IDX_W-1:0]           Q_i_in,
  input  logic [ROB_IDX_W-1:0]           Q_j_in,
  input  logic                           i_ready_in,
  input  logic                           j_ready_in,
  input  logic [NUM_CDB-1:0]             cdb_valid_in,
  input  logic [NUM_CDB*ROB_IDX_W-1:0]   cdb_rob_idx_in,
  input  logic [NUM_CDB*DATA_W-1:0]      cdb_data_in,
  input  logic                           flush_in,
  input  logic                           fu_busy_in,
  output logic                           rs_free_for_input_out,
  output logic [$clog2(DEPTH+1)-1:0]     count_out,
  output logic                           rs_output_valid_out,
  output logic [DATA_W-1:0]              rval1_out,
  output logic [DATA_W-1:0]              rval2_out,
  output logic [OP_W-1:0]                opcode_out,
  output logic [ROB_IDX_W-1:0]           rob_idx_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 busy;
    logic [OP_W-1:0]      opcode;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    vi;
    logic [DATA_W-1:0]    vj;
    logic [ROB_IDX_W-1:0] qi;
    logic [ROB_IDX_W-1:0] qj;
    logic                 ri;
    logic                 rj;
  } entry_t;

  entry_t             ent_q   [DEPTH];
  entry_t             woken_c [DEPTH+1];
  entry_t             next_c  [DEPTH];
  entry_t             disp_c;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_next_c;
  logic [CNT_W-1:0]   disp_slot_c;
  logic [IDX_W-1:0]   sel_idx_c;
  logic               sel_found_c;
  logic               issue_c;
  logic               do_disp_c;
  logic [DATA_W:0]    snoop_i_c [DEPTH];
  logic [DATA_W:0]    snoop_j_c [DEPTH];
  logic [DATA_W:0]    byp_i_c;
  logic [DATA_W:0]    byp_j_c;

  // Tag lookup across all buses; MSB is the hit flag, lowest bus index wins.
  function automatic logic [DATA_W:0] snoop(input logic [ROB_IDX_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (cdb_valid_in[k] && cdb_rob_idx_in[k*ROB_IDX_W +: ROB_IDX_W] == tag)
        r = {1'b1, cdb_data_in[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign rs_free_for_input_out = (count_q < CNT_W'(DEPTH));
  assign count_out             = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snoop_i_c[i] = snoop(ent_q[i].qi);
      snoop_j_c[i] = snoop(ent_q[i].qj);
    end
    byp_i_c = snoop(Q_i_in);
    byp_j_c = snoop(Q_j_in);
  end

  // Oldest ready entry, from registered state only.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (ent_q[i].busy && ent_q[i].ri && ent_q[i].rj) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IDX_W'(i);
      end
    end
  end

  assign issue_c     = sel_found_c && !fu_busy_in && !flush_in;
  assign do_disp_c   = valid_input_in && rs_free_for_input_out && !flush_in;
  assign disp_slot_c = count_q - CNT_W'(issue_c);

  // CDB wakeup of held entries; the extra top slot feeds an empty entry into compaction.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken_c[i] = ent_q[i];
      if (ent_q[i].busy && !ent_q[i].ri && snoop_i_c[i][DATA_W]) begin
        woken_c[i].vi = snoop_i_c[i][DATA_W-1:0];
        woken_c[i].ri = 1'b1;
      end
      if (ent_q[i].busy && !ent_q[i].rj && snoop_j_c[i][DATA_W]) begin
        woken_c[i].vj = snoop_j_c[i][DATA_W-1:0];
        woken_c[i].rj = 1'b1;
      end
    end
    woken_c[DEPTH] = '0;
  end

  // New entry with same-cycle bypass from the buses.
  always_comb begin
    disp_c         = '0;
    disp_c.busy    = 1'b1;
    disp_c.opcode  = opcode_in;
    disp_c.rob_idx = rob_idx_in;
    disp_c.qi      = Q_i_in;
    disp_c.qj      = Q_j_in;
    disp_c.vi      = i_ready_in ? V_i_in : byp_i_c[DATA_W-1:0];
    disp_c.vj      = j_ready_in ? V_j_in : byp_j_c[DATA_W-1:0];
    disp_c.ri      = i_ready_in | byp_i_c[DATA_W];
    disp_c.rj      = j_ready_in | byp_j_c[DATA_W];
  end

  // Compact over the issued slot, then place the dispatched entry at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      next_c[i] = woken_c[i];
      if (issue_c && (IDX_W'(i) >= sel_idx_c))
        next_c[i] = woken_c[i+1];
      if (do_disp_c && (CNT_W'(i) == disp_slot_c))
        next_c[i] = disp_c;
    end
    count_next_c = count_q - CNT_W'(issue_c) + CNT_W'(do_disp_c);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q             <= '0;
      rs_output_valid_out <= 1'b0;
      rval1_out           <= '0;
      rval2_out           <= '0;
      opcode_out          <= '0;
      rob_idx_out         <= '0;
    end else if (flush_in) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q             <= '0;
      rs_output_valid_out <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= next_c[i];
      count_q             <= count_next_c;
      rs_output_valid_out <= issue_c;
      if (issue_c) begin
        rval1_out   <= ent_q[sel_idx_c].vi;
        rval2_out   <= ent_q[sel_idx_c].vj;
        opcode_out  <= ent_q[sel_idx_c].opcode;
        rob_idx_out <= ent_q[sel_idx_c].rob_idx;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_array.sv
// Bench for reservation_station_array: directed scenarios plus randomized traffic
// checked against a queue-based model of the station.
module tb_reservation_station_array;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int OW    = 4;
  localparam int RW    = 3;
  localparam int NC    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic              clk_in, rst_in;
  logic              valid_input_in;
  logic [OW-1:0]     opcode_in;
  logic [RW-1:0]     rob_idx_in;
  logic [DW-1:0]     V_i_in, V_j_in;
  logic [RW-1:0]     Q_i_in, Q_j_in;
  logic              i_ready_in, j_ready_in;
  logic [NC-1:0]     cdb_valid_in;
  logic [NC*RW-1:0]  cdb_rob_idx_in;
  logic [NC*DW-1:0]  cdb_data_in;
  logic              flush_in, fu_busy_in;
  logic              rs_free_for_input_out;
  logic [CW-1:0]     count_out;
  logic              rs_output_valid_out;
  logic [DW-1:0]     rval1_out, rval2_out;
  logic [OW-1:0]     opcode_out;
  logic [RW-1:0]     rob_idx_out;

  int total = 0;
  int bad   = 0;

  reservation_station_array #(
    .DEPTH(DEPTH), .DATA_W(DW), .OP_W(OW), .ROB_IDX_W(RW), .NUM_CDB(NC)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_input_in(valid_input_in),
    .opcode_in(opcode_in), .rob_idx_in(rob_idx_in), .V_i_in(V_i_in), .V_j_in(V_j_in),
    .Q_i_in(Q_i_in), .Q_j_in(Q_j_in), .i_ready_in(i_ready_in), .j_ready_in(j_ready_in),
    .cdb_valid_in(cdb_valid_in), .cdb_rob_idx_in(cdb_rob_idx_in), .cdb_data_in(cdb_data_in),
    .flush_in(flush_in), .fu_busy_in(fu_busy_in),
    .rs_free_for_input_out(rs_free_for_input_out), .count_out(count_out),
    .rs_output_valid_out(rs_output_valid_out), .rval1_out(rval1_out), .rval2_out(rval2_out),
    .opcode_out(opcode_out), .rob_idx_out(rob_idx_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Reference model: an ordered list of waiting instructions.
  typedef struct {
    logic [OW-1:0] op;
    logic [RW-1:0] rob;
    logic [DW-1:0] vi, vj;
    logic [RW-1:0] qi, qj;
    logic          ri, rj;
  } ment_t;

  ment_t         mq[$];
  logic          ev;
  logic [DW-1:0] er1, er2;
  logic [OW-1:0] eop;
  logic [RW-1:0] erob;

  function automatic bit cdb_find(input logic [RW-1:0] tag, output logic [DW-1:0] d);
    d = '0;
    for (int k = 0; k < NC; k++)
      if (cdb_valid_in[k] && cdb_rob_idx_in[k*RW +: RW] == tag) begin
        d = cdb_data_in[k*DW +: DW];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_reset();
    mq.delete();
    ev = 0; er1 = '0; er2 = '0; eop = '0; erob = '0;
  endtask

  task automatic model_step();
    int idx;
    bit full;
    ment_t e;
    logic [DW-1:0] d;
    if (flush_in) begin
      mq.delete();
      ev = 0;
      return;
    end
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].ri && mq[i].rj) idx = i;
    full = (mq.size() >= DEPTH);
    foreach (mq[i]) begin
      if (!mq[i].ri && cdb_find(mq[i].qi, d)) begin mq[i].vi = d; mq[i].ri = 1; end
      if (!mq[i].rj && cdb_find(mq[i].qj, d)) begin mq[i].vj = d; mq[i].rj = 1; end
    end
    ev = 0;
    if (idx >= 0 && !fu_busy_in) begin
      ev = 1; er1 = mq[idx].vi; er2 = mq[idx].vj; eop = mq[idx].op; erob = mq[idx].rob;
      mq.delete(idx);
    end
    if (valid_input_in && !full) begin
      e.op = opcode_in; e.rob = rob_idx_in; e.qi = Q_i_in; e.qj = Q_j_in;
      e.vi = V_i_in; e.vj = V_j_in; e.ri = i_ready_in; e.rj = j_ready_in;
      if (!e.ri && cdb_find(Q_i_in, d)) begin e.vi = d; e.ri = 1; end
      if (!e.rj && cdb_find(Q_j_in, d)) begin e.vj = d; e.rj = 1; end
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    valid_input_in = 0; opcode_in = '0; rob_idx_in = '0; V_i_in = '0; V_j_in = '0;
    Q_i_in = '0; Q_j_in = '0; i_ready_in = 0; j_ready_in = 0;
    cdb_valid_in = '0; cdb_rob_idx_in = '0; cdb_data_in = '0;
    flush_in = 0; fu_busy_in = 0;
  endtask

  task automatic set_disp(input logic [OW-1:0] op, input logic [RW-1:0] rob,
                          input logic [DW-1:0] vi, input logic [DW-1:0] vj,
                          input logic [RW-1:0] qi, input logic [RW-1:0] qj,
                          input logic ri, input logic rj);
    valid_input_in = 1; opcode_in = op; rob_idx_in = rob; V_i_in = vi; V_j_in = vj;
    Q_i_in = qi; Q_j_in = qj; i_ready_in = ri; j_ready_in = rj;
  endtask

  task automatic test_reset();
    idle();
    rst_in = 0;
    model_reset();
    #23;
    total++; if (rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rs_output_valid_out); end
    total++; if (count_out !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    total++; if (rs_free_for_input_out !== 1'b1) begin bad++; $display("FAIL reset_free got=%b exp=1", rs_free_for_input_out); end
    total++; if ({rval1_out, rval2_out, opcode_out, rob_idx_out} !== '0) begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rval1_out, rval2_out, opcode_out, rob_idx_out); end
    rst_in = 1;
  endtask

  task automatic test_basic_add();
    set_disp(4'd0, 3'd2, 32'd5, 32'd7, '0, '0, 1, 1);
    tick();
    idle();
    total++; if (rs_output_valid_out !== 1'b0 || count_out !== 3'd1) begin bad++; $display("FAIL add_held valid=%b count=%0d exp valid=0 count=1", rs_output_valid_out, count_out); end
    tick();
    total++; if (rs_output_valid_out !== 1'b1 || rval1_out !== 32'd5 || rval2_out !== 32'd7 || rob_idx_out !== 3'd2 || opcode_out !== 4'd0)
      begin bad++; $display("FAIL add_issue valid=%b r1=%0d r2=%0d rob=%0d op=%0d exp 1/5/7/2/0", rs_output_valid_out, rval1_out, rval2_out, rob_idx_out, opcode_out); end
    total++; if (count_out !== 3'd0) begin bad++; $display("FAIL add_count got=%0d exp=0", count_out); end
    tick();
    total++; if (rs_output_valid_out !== 1'b0 || rval1_out !== 32'd5) begin bad++; $display("FAIL add_pulse valid=%b r1=%0d exp 0 and held 5", rs_output_valid_out, rval1_out); end
  endtask

  task automatic test_cdb_wakeup();
    set_disp(4'd3, 3'd1, 32'd0, 32'd3, 3'd4, '0, 0, 1);
    tick();
    idle();
    tick(); tick();
    total++; if (rs_output_valid_out !== 1'b0 || count_out !== 3'd1) begin bad++; $display("FAIL wake_wait valid=%b count=%0d exp 0/1", rs_output_valid_out, count_out); end
    cdb_valid_in = 2'b01; cdb_rob_idx_in = {3'd0, 3'd4}; cdb_data_in = {32'd0, 32'h1234};
    tick();
    idle();
    total++; if (rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL wake_capture valid=%b exp=0", rs_output_valid_out); end
    tick();
    total++; if (rs_output_valid_out !== 1'b1 || rval1_out !== 32'h1234 || rval2_out !== 32'd3 || rob_idx_out !== 3'd1)
      begin bad++; $display("FAIL wake_issue valid=%b r1=%h r2=%0d rob=%0d exp 1/1234/3/1", rs_output_valid_out, rval1_out, rval2_out, rob_idx_out); end
  endtask

  task automatic test_full();
    fu_busy_in = 1;
    for (int r = 0; r < 4; r++) begin
      set_disp(4'(r), 3'(r), 32'(100 + r), 32'(200 + r), '0, '0, 1, 1);
      tick();
    end
    total++; if (count_out !== 3'd4 || rs_free_for_input_out !== 1'b0) begin bad++; $display("FAIL full_count count=%0d free=%b exp 4/0", count_out, rs_free_for_input_out); end
    set_disp(4'd9, 3'd5, 32'd1, 32'd1, '0, '0, 1, 1);
    tick();
    total++; if (count_out !== 3'd4 || rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL full_ignore count=%0d valid=%b exp 4/0", count_out, rs_output_valid_out); end
    idle();
    for (int r = 0; r < 4; r++) begin
      tick();
      total++; if (rs_output_valid_out !== 1'b1 || rob_idx_out !== 3'(r) || rval1_out !== 32'(100 + r) || rval2_out !== 32'(200 + r))
        begin bad++; $display("FAIL full_order%0d valid=%b rob=%0d r1=%0d r2=%0d", r, rs_output_valid_out, rob_idx_out, rval1_out, rval2_out); end
    end
    tick();
    total++; if (count_out !== 3'd0 || rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL full_drain count=%0d valid=%b exp 0/0", count_out, rs_output_valid_out); end
  endtask

  task automatic test_bypass();
    set_disp(4'd2, 3'd3, 32'd11, 32'd0, '0, 3'd6, 1, 0);
    cdb_valid_in = 2'b11; cdb_rob_idx_in = {3'd6, 3'd1}; cdb_data_in = {32'd99, 32'd55};
    tick();
    idle();
    tick();
    total++; if (rs_output_valid_out !== 1'b1 || rval1_out !== 32'd11 || rval2_out !== 32'd99 || rob_idx_out !== 3'd3)
      begin bad++; $display("FAIL bypass valid=%b r1=%0d r2=%0d rob=%0d exp 1/11/99/3", rs_output_valid_out, rval1_out, rval2_out, rob_idx_out); end
  endtask

  task automatic test_out_of_order();
    set_disp(4'd1, 3'd4, 32'd0, 32'd8, 3'd5, '0, 0, 1);
    tick();
    set_disp(4'd6, 3'd5, 32'd10, 32'd20, '0, '0, 1, 1);
    tick();
    idle();
    tick();
    total++; if (rs_output_valid_out !== 1'b1 || rob_idx_out !== 3'd5 || rval1_out !== 32'd10 || count_out !== 3'd1)
      begin bad++; $display("FAIL ooo_young valid=%b rob=%0d r1=%0d count=%0d exp 1/5/10/1", rs_output_valid_out, rob_idx_out, rval1_out, count_out); end
    cdb_valid_in = 2'b11; cdb_rob_idx_in = {3'd5, 3'd5}; cdb_data_in = {32'd88, 32'd77};
    tick();
    idle();
    tick();
    total++; if (rs_output_valid_out !== 1'b1 || rob_idx_out !== 3'd4 || rval1_out !== 32'd77 || rval2_out !== 32'd8)
      begin bad++; $display("FAIL ooo_old valid=%b rob=%0d r1=%0d r2=%0d exp 1/4/77/8", rs_output_valid_out, rob_idx_out, rval1_out, rval2_out); end
  endtask

  task automatic test_flush_reset();
    fu_busy_in = 1;
    for (int r = 0; r < 3; r++) begin
      set_disp(4'd7, 3'(r), 32'd1, 32'd2, '0, '0, 1, 1);
      tick();
    end
    total++; if (count_out !== 3'd3) begin bad++; $display("FAIL flush_pre count=%0d exp=3", count_out); end
    fu_busy_in = 0; flush_in = 1;
    set_disp(4'd7, 3'd7, 32'd1, 32'd2, '0, '0, 1, 1);
    tick();
    idle();
    total++; if (count_out !== 3'd0 || rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL flush count=%0d valid=%b exp 0/0", count_out, rs_output_valid_out); end
    tick();
    total++; if (count_out !== 3'd0 || rs_output_valid_out !== 1'b0) begin bad++; $display("FAIL flush_after count=%0d valid=%b exp 0/0", count_out, rs_output_valid_out); end
    set_disp(4'd2, 3'd6, 32'd0, 32'd4, 3'd2, '0, 0, 1);
    tick();
    idle();
    cdb_valid_in = 2'b01; cdb_rob_idx_in = {3'd0, 3'd2}; cdb_data_in = {32'd0, 32'hdead};
    #2;
    rst_in = 0;
    #1;
    total++; if (rs_output_valid_out !== 1'b0 || count_out !== 3'd0 || rs_free_for_input_out !== 1'b1)
      begin bad++; $display("FAIL async_rst_ctl valid=%b count=%0d free=%b exp 0/0/1", rs_output_valid_out, count_out, rs_free_for_input_out); end
    total++; if ({rval1_out, rval2_out, opcode_out, rob_idx_out} !== '0) begin bad++; $display("FAIL async_rst_data got=%h/%h/%h/%h exp=0", rval1_out, rval2_out, opcode_out, rob_idx_out); end
    model_reset();
    idle();
    #1;
    rst_in = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid_input_in = ($urandom_range(0, 9) < 6);
      opcode_in = OW'($urandom); rob_idx_in = RW'($urandom);
      V_i_in = $urandom; V_j_in = $urandom;
      Q_i_in = RW'($urandom); Q_j_in = RW'($urandom);
      i_ready_in = ($urandom_range(0, 1) == 1); j_ready_in = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < NC; k++) cdb_valid_in[k] = ($urandom_range(0, 9) < 4);
      cdb_rob_idx_in = (NC*RW)'($urandom);
      cdb_data_in = {$urandom, $urandom};
      fu_busy_in = ($urandom_range(0, 9) < 3);
      flush_in = ($urandom_range(0, 99) < 3);
      tick();
      total++; if (rs_output_valid_out !== ev) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, rs_output_valid_out, ev); end
      total++; if (count_out !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count_out, mq.size()); end
      total++; if (rs_free_for_input_out !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_free cyc=%0d got=%b", c, rs_free_for_input_out); end
      total++; if (rval1_out !== er1 || rval2_out !== er2) begin bad++; $display("FAIL rnd_vals cyc=%0d got=%h/%h exp=%h/%h", c, rval1_out, rval2_out, er1, er2); end
      total++; if (opcode_out !== eop || rob_idx_out !== erob) begin bad++; $display("FAIL rnd_tag cyc=%0d got op=%0d rob=%0d exp op=%0d rob=%0d", c, opcode_out, rob_idx_out, eop, erob); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_cdb_wakeup();
    test_full();
    test_bypass();
    test_out_of_order();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reservation_station_array.md
Name: reservation_station_array

Overview:
- Multi-entry, parametrised successor to the single-slot reservation station in the Tomasulo superscalar core.
- Sits between decode/issue and one functional unit (ALU, branch ALU, MUL, DIV or MEM).
- Holds up to DEPTH waiting instructions and snoops NUM_CDB common data buses to wake up pending operands.
- Each cycle, issues the oldest fully-ready entry to its FU when the FU is not busy.

Parameters:
DEPTH, 4, number of entries (>=2)
DATA_W, 32, operand width
OP_W, 4, opcode width
ROB_IDX_W, 3, ROB tag width
NUM_CDB, 2, number of CDB broadcast ports (>=1)

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-low reset
valid_input_in  input  1  dispatch request
opcode_in  input  OP_W  dispatched opcode
rob_idx_in  input  ROB_IDX_W  destination ROB tag
V_i_in  input  DATA_W  operand i value (meaningful when i_ready_in)
V_j_in  input  DATA_W  operand j value (meaningful when j_ready_in)
Q_i_in  input  ROB_IDX_W  producer tag for i when not ready
Q_j_in  input  ROB_IDX_W  producer tag for j when not ready
i_ready_in  input  1  operand i value valid
j_ready_in  input  1  operand j value valid
cdb_valid_in  input  NUM_CDB  per-bus broadcast valid
cdb_rob_idx_in  input  NUM_CDB*ROB_IDX_W  per-bus tag, bus k at bits [k*ROB_IDX_W +: ROB_IDX_W]
cdb_data_in  input  NUM_CDB*DATA_W  per-bus result, bus k at bits [k*DATA_W +: DATA_W]
flush_in  input  1  synchronous squash of all entries
fu_busy_in  input  1  FU cannot accept this cycle
rs_free_for_input_out  output  1  at least one free entry
count_out  output  $clog2(DEPTH+1)  occupied entries
rs_output_valid_out  output  1  one-cycle pulse: issued op valid
rval1_out  output  DATA_W  issued operand i
rval2_out  output  DATA_W  issued operand j
opcode_out  output  OP_W  issued opcode
rob_idx_out  output  ROB_IDX_W  issued ROB tag

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All entries invalid; count_out=0; rs_free_for_input_out=1.
  - rs_output_valid_out=0; rval1_out, rval2_out, opcode_out and rob_idx_out are 0.
  - Reset mid-operation drops all held entries and any pending output.
- Entry fields: busy, opcode, rob_idx, Vi, Vj, Qi, Qj, ri, rj. Entries are kept age-ordered with slot 0 the oldest; the array compacts (shifts toward 0) on issue.
- rs_free_for_input_out = (count < DEPTH), computed combinationally from registered occupancy only.
  - An issue in the same cycle does not free space for a same-cycle dispatch when full.
- Dispatch: when valid_input_in && rs_free_for_input_out, write at the first free slot after compaction. Dispatch while full is ignored.
- Same-cycle bypass: if operand i is not ready and some CDB k has cdb_valid_in[k] with tag == Q_i_in in the dispatch cycle, capture that data and set ri=1. Operand j is handled identically.
- Wakeup: every cycle, each busy entry with ri=0 whose Qi matches a valid CDB tag captures the data and sets ri. Same for j.
  - If multiple buses match, the lowest bus index wins.
- Issue selection uses registered state only: the lowest-index busy entry with ri && rj. A CDB wakeup becomes issuable the cycle after capture.
- Issue occurs when a candidate exists and fu_busy_in=0. On the next edge:
  - Output registers load the entry's fields and rs_output_valid_out=1 for exactly one cycle.
  - The entry is removed and younger entries shift down.
- If no issue occurs, rs_output_valid_out=0 and the data outputs hold their last values.
- Latency: a ready-at-dispatch instruction into an empty station issues on the edge after dispatch, so output is valid 2 cycles after valid_input_in.
- Simultaneous issue and dispatch (not full): both occur. The new entry lands at index count-1 after compaction; count is unchanged.
- CDB wakeup on an entry that is shifting in the same cycle: the captured data moves with the entry.
- flush_in=1: all entries are cleared on the next edge and rs_output_valid_out=0. Flush overrides dispatch and issue in that cycle.
- count_out tracks occupancy exactly and saturates only by construction (never exceeds DEPTH).

Test Plan:
- Reset, then dispatch ADD (opcode 0, rob 2, Vi=5, Vj=7, both ready) -> 2 cycles later rs_output_valid_out=1 for one cycle with rval1=5, rval2=7, rob_idx=2; count returns to 0.
- Dispatch rob 1 with Qi=4 not ready; 3 cycles later CDB0 tag 4 data 0x1234 -> rval1_out=0x1234 issues the cycle after capture.
- Dispatch 4 ready ops with fu_busy_in=1 -> count=4, rs_free_for_input_out=0; a fifth dispatch is ignored; deassert busy -> issue order rob 0,1,2,3, one per cycle.
- Dispatch Qj=6 while CDB1 broadcasts tag 6 data 99 in the same cycle -> entry is ready immediately and issues with rval2=99.
- Two entries: older waiting, younger ready -> younger issues first; older then issues after its CDB wakeup.
- Three entries held, pulse flush_in with a simultaneous dispatch -> count=0, no output pulse; assert rst_in=0 mid-wakeup -> all outputs 0 asynchronously.
